// File: rtl/bitonic_loader.sv
// Serial-to-parallel front end for the bitonic network: packs a batch of
// elements into one flat vector, pulses valid, then waits for done.
module bitonic_loader #(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    NODE_ORDER  = 3,
  parameter int                    NODE_DWIDTH = 64,
  parameter logic [DATA_WIDTH-1:0] PAD_VALUE   = {DATA_WIDTH{1'b1}}
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic                   in_valid,
  input  logic                   in_last,
  output logic                   in_ready,
  output logic                   valid,
  output logic [NODE_DWIDTH-1:0] data_in,
  input  logic                   done,
  output logic                   busy,
  output logic [NODE_ORDER:0]    count
);

  localparam int                NUM_ELEM = 2 ** NODE_ORDER;
  localparam logic [NODE_ORDER:0] LAST_IDX = (NODE_ORDER + 1)'(NUM_ELEM - 1);
  localparam logic [NODE_ORDER:0] FULL_CNT = (NODE_ORDER + 1)'(NUM_ELEM);

  generate
    if (NODE_DWIDTH != DATA_WIDTH * NUM_ELEM) begin : g_bad_width
      $error("bitonic_loader: NODE_DWIDTH must equal DATA_WIDTH*2**NODE_ORDER");
    end
    if (NODE_ORDER < 1 || NODE_ORDER > 6) begin : g_bad_order
      $error("bitonic_loader: NODE_ORDER must be within 1..6");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_FILL,
    ST_ISSUE,
    ST_WAIT
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic                    ready_en;
  logic                    done_q;
  logic                    accept;
  logic                    batch_end;
  logic                    done_rise;
  logic [NODE_DWIDTH-1:0]  data_nxt;

  assign accept    = in_valid & in_ready;
  assign batch_end = accept & (in_last | (count == LAST_IDX));
  assign done_rise = done & ~done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_FILL;
    end else begin
      state <= state_nxt;
    end
  end

  // A done level left over from before the issue cycle is already in done_q,
  // so only a fresh rise observed in WAIT releases the batch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_FILL:  if (batch_end) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT:  if (done_rise) state_nxt = ST_FILL;
      default:  state_nxt = ST_FILL;
    endcase
  end

  always_comb begin
    in_ready = (state == ST_FILL) & ready_en;
    valid    = (state == ST_ISSUE);
    busy     = (state != ST_FILL);
  end

  // Current slot takes the element; on an early last every higher slot is padded.
  always_comb begin
    data_nxt = data_in;
    for (int i = 0; i < NUM_ELEM; i++) begin
      if ((NODE_ORDER + 1)'(i) == count) begin
        data_nxt[DATA_WIDTH*i +: DATA_WIDTH] = in_data;
      end else if (in_last && ((NODE_ORDER + 1)'(i) > count)) begin
        data_nxt[DATA_WIDTH*i +: DATA_WIDTH] = PAD_VALUE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ready_en <= 1'b0;
      done_q   <= 1'b0;
      count    <= '0;
      data_in  <= '0;
    end else begin
      ready_en <= 1'b1;
      done_q   <= done;
      if (accept) begin
        data_in <= data_nxt;
        if (count != FULL_CNT) begin
          count <= count + 1'b1;
        end
      end else if (state == ST_WAIT && done_rise) begin
        count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_bitonic_loader.sv
// Directed and randomized checks of bitonic_loader against a queue-based
// reference of the accepted elements.
module tb_bitonic_loader;

  localparam int          DW  = 8;
  localparam int          NO  = 3;
  localparam int          NE  = 8;
  localparam int          NDW = 64;
  localparam logic [7:0]  PAD = 8'hFF;

  logic           clk = 1'b0;
  logic           reset;
  logic [DW-1:0]  in_data;
  logic           in_valid;
  logic           in_last;
  logic           in_ready;
  logic           valid;
  logic [NDW-1:0] data_in;
  logic           done;
  logic           busy;
  logic [NO:0]    count;

  int vectors      = 0;
  int miscompares  = 0;
  int valid_pulses = 0;

  bitonic_loader #(
    .DATA_WIDTH  (DW),
    .NODE_ORDER  (NO),
    .NODE_DWIDTH (NDW),
    .PAD_VALUE   (PAD)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .valid    (valid),
    .data_in  (data_in),
    .done     (done),
    .busy     (busy),
    .count    (count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (valid === 1'b1) valid_pulses++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: element k lands in byte k, unfilled bytes hold the pad value.
  function automatic logic [63:0] pack_ref(input logic [7:0] q[$]);
    logic [63:0] v;
    for (int k = 0; k < NE; k++) begin
      v[k*8 +: 8] = (k < q.size()) ? q[k] : PAD;
    end
    return v;
  endfunction

  task automatic applyStimulus(input logic [7:0] elems[$], input bit use_last,
                               input bit gappy, output logic [63:0] exp_vec);
    for (int k = 0; k < elems.size(); k++) begin
      int attempts = 0;
      bit accepted = 1'b0;
      while (!accepted) begin
        checkOutput("fill_ready", 64'(in_ready), 64'd1);
        checkOutput("fill_count", 64'(count), 64'(k));
        in_valid = (!gappy || attempts >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
        in_data  = in_valid ? elems[k] : 8'($urandom);
        in_last  = use_last && (k == elems.size() - 1);
        accepted = in_valid;
        attempts++;
        tick;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'($urandom);
    exp_vec  = pack_ref(elems);
    checkOutput("issue_valid", 64'(valid), 64'd1);
    checkOutput("issue_busy", 64'(busy), 64'd1);
    checkOutput("issue_ready", 64'(in_ready), 64'd0);
    checkOutput("issue_data", data_in, exp_vec);
    checkOutput("issue_count", 64'(count), 64'(elems.size()));
  endtask

  task automatic check_waiting(input logic [63:0] exp_vec, input int exp_cnt);
    checkOutput("wait_valid", 64'(valid), 64'd0);
    checkOutput("wait_busy", 64'(busy), 64'd1);
    checkOutput("wait_ready", 64'(in_ready), 64'd0);
    checkOutput("wait_data", data_in, exp_vec);
    checkOutput("wait_count", 64'(count), 64'(exp_cnt));
  endtask

  task automatic check_released(input logic [63:0] exp_vec);
    checkOutput("rel_busy", 64'(busy), 64'd0);
    checkOutput("rel_ready", 64'(in_ready), 64'd1);
    checkOutput("rel_count", 64'(count), 64'd0);
    checkOutput("rel_valid", 64'(valid), 64'd0);
    checkOutput("rel_data", data_in, exp_vec);
  endtask

  // Called in the issue cycle; done rises after rise_after cycles of WAIT.
  task automatic wait_done(input int rise_after, input bit hold_valid,
                           input logic [63:0] exp_vec, input int exp_cnt);
    done = 1'b0;
    if (hold_valid) begin
      in_valid = 1'b1;
      in_data  = 8'hAA;
    end
    for (int i = 0; i < rise_after; i++) begin
      tick;
      check_waiting(exp_vec, exp_cnt);
    end
    done = 1'b1;
    tick;
    in_valid = 1'b0;
    done     = 1'b0;
    check_released(exp_vec);
  endtask

  task automatic check_reset_state(input string tag);
    checkOutput({tag, "_ready"}, 64'(in_ready), 64'd0);
    checkOutput({tag, "_valid"}, 64'(valid), 64'd0);
    checkOutput({tag, "_data"}, data_in, 64'd0);
    checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
    checkOutput({tag, "_count"}, 64'(count), 64'd0);
  endtask

  initial begin
    logic [7:0]  q[$];
    logic [63:0] v;
    int          pulses_before;

    reset    = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
    done     = 1'b0;
    tick;
    tick;
    check_reset_state("reset");
    reset = 1'b0;
    tick;
    checkOutput("post_reset_ready", 64'(in_ready), 64'd1);

    $display("[TB] full batch 07..00");
    q = {8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00};
    applyStimulus(q, 1'b0, 1'b0, v);
    checkOutput("full_const", data_in, 64'h0001020304050607);
    wait_done(4, 1'b0, v, 8);

    $display("[TB] early last after three elements");
    q = {8'h11, 8'h22, 8'h33};
    applyStimulus(q, 1'b1, 1'b0, v);
    checkOutput("early_const", data_in, 64'hFFFFFFFFFF332211);
    wait_done(2, 1'b0, v, 3);

    $display("[TB] stale done held across issue");
    q = {};
    for (int i = 0; i < NE; i++) q.push_back(8'($urandom));
    done = 1'b1;
    applyStimulus(q, 1'b1, 1'b0, v);
    tick;
    check_waiting(v, 8);
    tick;
    check_waiting(v, 8);
    done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      check_waiting(v, 8);
    end
    done = 1'b1;
    tick;
    done = 1'b0;
    check_released(v);

    $display("[TB] gapped input, in_valid held during wait");
    q = {};
    for (int i = 0; i < NE; i++) q.push_back(8'($urandom));
    applyStimulus(q, 1'b0, 1'b1, v);
    wait_done(3, 1'b1, v, 8);

    $display("[TB] reset in the middle of a fill");
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      tick;
    end
    in_valid = 1'b0;
    checkOutput("partial_count", 64'(count), 64'd5);
    reset = 1'b1;
    tick;
    check_reset_state("midreset");
    reset = 1'b0;
    tick;
    checkOutput("midreset_ready", 64'(in_ready), 64'd1);
    q = {};
    for (int i = 0; i < NE; i++) q.push_back(8'($urandom));
    applyStimulus(q, 1'b0, 1'b0, v);
    wait_done(4, 1'b0, v, 8);

    $display("[TB] three back-to-back batches");
    pulses_before = valid_pulses;
    for (int b = 0; b < 3; b++) begin
      q = {};
      for (int i = 0; i < NE; i++) q.push_back(8'($urandom));
      applyStimulus(q, 1'b0, 1'b0, v);
      wait_done(4, 1'b0, v, 8);
    end
    checkOutput("b2b_pulses", 64'(valid_pulses - pulses_before), 64'd3);
    checkOutput("total_pulses", 64'(valid_pulses), 64'd8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
